// File: rtl/spi_master_engine.sv
// spi_master_engine: byte-wide SPI mode-0 initiator.
// SCK half-period = max(clkdiv,1) clk cycles; chip select is driven by separate
// assert/release commands with a minimum high time after each release.
// Optional feature macro: SPI_MASTER_LSB_FIRST_EN adds the lsb_first input.
module spi_master_engine #(
  parameter int DIV_WIDTH       = 16,
  parameter int CS_RELEASE_HOLD = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] clkdiv,
  input  logic                 shift_en,
  input  logic [7:0]           tx_data,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic                 lsb_first,
`endif
  input  logic                 cs_assert,
  input  logic                 cs_release,
  output logic                 busy,
  output logic                 rx_valid,
  output logic [7:0]           rx_data,
  output logic                 spi_sck,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic                 spi_cs_n
);

  localparam int HOLD_W = (CS_RELEASE_HOLD < 2) ? 1 : $clog2(CS_RELEASE_HOLD + 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t               state, state_nxt;
  logic [DIV_WIDTH-1:0] half, cnt, h_new;
  logic [2:0]           bit_cnt;
  logic [7:0]           tx_sh, rx_sh;
  logic                 tick, start;
  logic                 lsb_start, lsb_mode;
  logic                 rel_pend, asrt_pend, rel_now, asrt_req;
  logic [HOLD_W-1:0]    hold_cnt;

  assign start = (state == IDLE) && shift_en;
  assign tick  = (cnt == '0);
  assign h_new = (clkdiv == '0) ? DIV_WIDTH'(1) : clkdiv;
  assign busy  = (state != IDLE);

`ifdef SPI_MASTER_LSB_FIRST_EN
  logic lsb_q;
  assign lsb_start = lsb_first;
  assign lsb_mode  = lsb_q;

  // Bit order is captured with the transfer and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     lsb_q <= 1'b0;
    else if (start) lsb_q <= lsb_first;
  end
`else
  assign lsb_start = 1'b0;
  assign lsb_mode  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: alternate LOW/HIGH half-periods, leave after the 8th falling edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (shift_en) state_nxt = LOW;
      LOW:     if (tick) state_nxt = HIGH;
      HIGH:    if (tick) state_nxt = (bit_cnt == 3'd7) ? IDLE : LOW;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: half-period timer, bit counter, shift registers, SCK/MOSI and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half     <= '0;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      spi_mosi <= 1'b0;
      spi_sck  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      spi_sck  <= (state_nxt == HIGH);
      case (state)
        IDLE: begin
          if (shift_en) begin
            half     <= h_new;
            cnt      <= h_new - DIV_WIDTH'(1);
            bit_cnt  <= '0;
            tx_sh    <= tx_data;
            spi_mosi <= lsb_start ? tx_data[0] : tx_data[7];
          end
        end
        LOW: begin
          if (tick) begin
            cnt   <= half - DIV_WIDTH'(1);
            rx_sh <= lsb_mode ? {spi_miso, rx_sh[7:1]} : {rx_sh[6:0], spi_miso};
          end else begin
            cnt <= cnt - DIV_WIDTH'(1);
          end
        end
        HIGH: begin
          if (tick) begin
            cnt <= half - DIV_WIDTH'(1);
            if (bit_cnt == 3'd7) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_sh;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              tx_sh    <= lsb_mode ? (tx_sh >> 1) : (tx_sh << 1);
              spi_mosi <= lsb_mode ? tx_sh[1] : tx_sh[6];
            end
          end else begin
            cnt <= cnt - DIV_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // A release only takes effect in IDLE with no transfer starting; otherwise it waits.
  // A same-cycle release cancels any assert; asserts during the hold time are queued.
  assign rel_now  = (cs_release || rel_pend) && !busy && !start;
  assign asrt_req = (cs_assert || asrt_pend) && !cs_release;

  // Chip-select control with release hold-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_cs_n  <= 1'b1;
      rel_pend  <= 1'b0;
      asrt_pend <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
      if (rel_now) begin
        spi_cs_n  <= 1'b1;
        hold_cnt  <= HOLD_W'(CS_RELEASE_HOLD);
        rel_pend  <= 1'b0;
        asrt_pend <= asrt_req;
      end else begin
        if (cs_release) rel_pend <= 1'b1;
        if (asrt_req) begin
          if (hold_cnt != '0) begin
            asrt_pend <= 1'b1;
          end else begin
            spi_cs_n  <= 1'b0;
            asrt_pend <= 1'b0;
          end
        end else begin
          asrt_pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// Testbench for spi_master_engine: scoreboard of issued transfers, a SPI slave
// model driving MISO, and a monitor checking edge timing, MOSI bits and results.
module tb_spi_master_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] clkdiv = '0;
  logic        shift_en = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        cs_assert = 1'b0;
  logic        cs_release = 1'b0;
  logic        busy, rx_valid, spi_sck, spi_mosi, spi_cs_n;
  logic [7:0]  rx_data;
  logic        spi_miso = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic        lsb_first = 1'b0;
`endif

  spi_master_engine #(.DIV_WIDTH(16), .CS_RELEASE_HOLD(2)) dut (
    .clk(clk), .rst_n(rst_n), .clkdiv(clkdiv), .shift_en(shift_en), .tx_data(tx_data),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .cs_assert(cs_assert), .cs_release(cs_release), .busy(busy), .rx_valid(rx_valid),
    .rx_data(rx_data), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] mb;
    int         h;
    int         start;
    bit         lsb;
  } xfer_t;

  xfer_t q[$];
  int    cyc = 0;
  int    total = 0, bad = 0;
  int    rx_cnt = 0, rx_seen = 0, pushed = 0;
  int    rises = 0, falls = 0;
  bit    prev_sck = 1'b0;
  int    last_start = 0, last_done = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string nm);
    total++;
    bad++;
    $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      fail_evt("transfer_timeout");
      q.delete();
    end
  endtask

  // Issue a transfer in the current cycle (cycle 0); returns in cycle 1.
  task automatic start_xfer(input logic [7:0] tx, input logic [7:0] mb, input logic [15:0] div,
                            input bit cs, input bit lsb);
    xfer_t e;
    shift_en  = 1'b1;
    tx_data   = tx;
    clkdiv    = div;
    cs_assert = cs;
    e.tx = tx;
    e.mb = mb;
    e.h  = (div == 0) ? 1 : int'(div);
    e.start = cyc;
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_first = lsb;
    e.lsb = lsb;
`else
    e.lsb = 1'b0;
`endif
    q.push_back(e);
    pushed++;
    last_start = cyc;
    last_done  = cyc + 1 + 16 * e.h;
    tick();
    shift_en  = 1'b0;
    cs_assert = 1'b0;
    clkdiv    = 16'($urandom_range(0, 9));
    tx_data   = 8'($urandom);
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_first = 1'($urandom);
`endif
  endtask

  // Monitor + slave model: checks every SCK edge time, MOSI bit and result against q[0].
  always @(negedge clk) begin
    xfer_t e;
    int    bi;
    if (q.size() == 0) begin
      rises = 0;
      falls = 0;
    end
    if (rst_n) begin
      if (spi_sck && !prev_sck) begin
        if (q.size() == 0 || rises > 7) fail_evt("sck_rise_unexpected");
        else begin
          chk("rise_time", cyc, q[0].start + 1 + (2 * rises + 1) * q[0].h);
          bi = q[0].lsb ? rises : 7 - rises;
          chk("mosi_bit", spi_mosi, q[0].tx[bi]);
          rises++;
        end
      end
      if (!spi_sck && prev_sck && q.size() > 0) begin
        chk("fall_time", cyc, q[0].start + 1 + (2 * falls + 2) * q[0].h);
        falls++;
      end
      if (rx_valid) begin
        rx_seen++;
        if (q.size() == 0) fail_evt("rx_valid_unexpected");
        else begin
          e = q.pop_front();
          chk("rx_data", rx_data, e.mb);
          chk("latency", cyc - e.start, 1 + 16 * e.h);
          chk("rise_count", rises, 8);
          chk("busy_at_done", busy, 0);
          rx_cnt++;
          rises = 0;
          falls = 0;
        end
      end
    end
    prev_sck = spi_sck;
    if (q.size() > 0 && rises < 8) spi_miso = q[0].lsb ? q[0].mb[rises] : q[0].mb[7 - rises];
    else spi_miso = 1'b0;
  end

  initial begin
    int errs;
    int c0;
    int c;

    // 1: reset and idle
    repeat (5) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sck", spi_sck, 0);
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_rx_valid", rx_valid, 0);
    errs = 0;
    repeat (100) begin
      @(negedge clk);
      if (spi_sck !== 1'b0 || spi_cs_n !== 1'b1 || busy !== 1'b0 || rx_valid !== 1'b0) errs++;
    end
    chk("idle_quiet", errs, 0);
    tick();

    // 2: clkdiv=4, tx A5, slave 3C, CS asserted with shift_en
    start_xfer(8'hA5, 8'h3C, 16'd4, 1'b1, 1'b0);
    @(negedge clk);
    chk("cyc1_busy", busy, 1);
    chk("cyc1_mosi", spi_mosi, 1);
    chk("cyc1_sck", spi_sck, 0);
    chk("cyc1_cs_n", spi_cs_n, 0);
    tick();
    wait_idle();

    // 3: back-to-back with an ignored mid-transfer shift_en
    c0 = rx_seen;
    start_xfer(8'h01, 8'($urandom), 16'd2, 1'b0, 1'b0);
    wait_to(last_start + 10);
    shift_en = 1'b1;
    tx_data  = 8'h55;
    clkdiv   = 16'd1;
    tick();
    shift_en = 1'b0;
    wait_to(last_done);
    start_xfer(8'hFF, 8'($urandom), 16'd3, 1'b0, 1'b0);
    wait_idle();
    repeat (10) tick();
    chk("b2b_rx_count", rx_seen - c0, 2);

    // 4: release deferred to end of transfer, then assert delayed by hold time
    start_xfer(8'($urandom), 8'($urandom), 16'd2, 1'b1, 1'b0);
    wait_to(last_start + 3);
    cs_release = 1'b1;
    tick();
    cs_release = 1'b0;
    errs = 0;
    while (cyc <= last_done) begin
      @(negedge clk);
      if (spi_cs_n !== 1'b0) errs++;
      tick();
    end
    chk("cs_low_during_xfer", errs, 0);
    cs_assert = 1'b1;
    @(negedge clk);
    chk("cs_released_after_done", spi_cs_n, 1);
    tick();
    cs_assert = 1'b0;
    @(negedge clk);
    chk("cs_hold_1", spi_cs_n, 1);
    tick();
    @(negedge clk);
    chk("cs_hold_2", spi_cs_n, 1);
    tick();
    @(negedge clk);
    chk("cs_assert_after_hold", spi_cs_n, 0);
    tick();
    // release in idle is immediate; assert+release together: release wins
    cs_release = 1'b1;
    tick();
    cs_release = 1'b0;
    @(negedge clk);
    chk("cs_idle_release", spi_cs_n, 1);
    repeat (4) tick();
    c = cyc;
    cs_assert  = 1'b1;
    cs_release = 1'b1;
    tick();
    cs_assert  = 1'b0;
    cs_release = 1'b0;
    @(negedge clk);
    chk("cs_both_release_wins", spi_cs_n, 1);
    wait_to(c + 3);
    @(negedge clk);
    chk("cs_both_no_late_assert", spi_cs_n, 1);
    cs_assert = 1'b1;
    tick();
    cs_assert = 1'b0;
    @(negedge clk);
    chk("cs_assert_immediate", spi_cs_n, 0);
    tick();

    // 5: clkdiv 0 and 1 both give H=1
    start_xfer(8'($urandom), 8'($urandom), 16'd0, 1'b0, 1'b0);
    wait_idle();
    start_xfer(8'($urandom), 8'($urandom), 16'd1, 1'b0, 1'b0);
    wait_idle();

    // 6: reset mid-transfer aborts, then a fresh transfer completes
    c0 = rx_seen;
    start_xfer(8'($urandom), 8'($urandom), 16'd4, 1'b1, 1'b0);
    wait_to(last_start + 20);
    rst_n = 1'b0;
    q.delete();
    pushed--;
    #1;
    chk("abort_sck", spi_sck, 0);
    chk("abort_cs_n", spi_cs_n, 1);
    chk("abort_busy", busy, 0);
    chk("abort_mosi", spi_mosi, 0);
    chk("abort_rx_data", rx_data, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (80) tick();
    chk("abort_no_rx_valid", rx_seen - c0, 0);
    start_xfer(8'($urandom), 8'($urandom), 16'd3, 1'b1, 1'b0);
    wait_idle();

`ifdef SPI_MASTER_LSB_FIRST_EN
    // 7: LSB-first
    start_xfer(8'h01, 8'h80, 16'd4, 1'b0, 1'b1);
    @(negedge clk);
    chk("lsb_first_bit", spi_mosi, 1);
    tick();
    wait_idle();
`endif

    // Random transfers, some issued in the rx_valid cycle of the previous one
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) wait_to(last_done);
      else begin
        wait_idle();
        repeat ($urandom_range(0, 3)) tick();
      end
      start_xfer(8'($urandom), 8'($urandom), 16'($urandom_range(0, 5)), 1'($urandom), 1'($urandom));
    end
    wait_idle();
    repeat (10) tick();
    chk("total_rx_count", rx_cnt, pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
